apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  APB requester end: converts a simple valid/ready command port into APB3 transfers (SETUP->ACCESS)
//  and returns read data/status on a valid/ready response port. Sits between a local controller
//  (test sequencer, DMA/config engine) and the I2S block's APB completer.
//  One transfer in flight; wait states via pready; watchdog aborts a hung completer.
// PARAMETERS
//  APB_ADDR_WIDTH  32  paddr / req_addr width
//  APB_DATA_WIDTH  32  pwdata / prdata / req_wdata / rsp_rdata width
//  TIMEOUT_CYCLES  16  max ACCESS cycles with pready low before abort; 0 disables the watchdog
// PORTS
//  pclk         in   1               single clock, all logic rising-edge
//  prst         in   1               asynchronous, active-high reset
//  req_valid    in   1               command present
//  req_ready    out  1               command accepted when req_valid & req_ready
//  req_addr     in   APB_ADDR_WIDTH  target address
//  req_write    in   1               1 = write, 0 = read
//  req_wdata    in   APB_DATA_WIDTH   write data (ignored for reads)
//  rsp_valid    out  1               response available; held until rsp_ready
//  rsp_ready    in   1               response consumed
//  rsp_rdata    out  APB_DATA_WIDTH   read data (0 for writes, errors and timeouts)
//  rsp_err      out  1               pslverr seen or timeout
//  rsp_timeout  out  1               transfer aborted by watchdog
//  paddr/psel/penable/pwrite/pwdata   out  APB master signals (widths per parameters)
//  prdata/pready/pslverr              in   APB completer return signals
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0,
//    rsp_timeout=0, rsp_rdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, watchdog=0.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//    IDLE  : req_ready=1; on req_valid capture addr/write/wdata into paddr/pwrite/pwdata,
//            req_ready<=0, go SETUP.
//    SETUP : psel=1, penable=0; exactly one cycle; next ACCESS.
//    ACCESS: psel=1, penable=1; each cycle sample pready. pready=1 -> capture
//            rsp_rdata = pwrite ? 0 : (pslverr ? 0 : prdata), rsp_err=pslverr; drop psel/penable; go RESP.
//            pready=0 -> watchdog++; when watchdog==TIMEOUT_CYCLES (param!=0) drop psel/penable,
//            rsp_err=1, rsp_timeout=1, rsp_rdata=0, go RESP.
//    RESP  : rsp_valid=1, fields stable; on rsp_ready -> rsp_valid=0, clear err/timeout, go IDLE
//            (req_ready=1 next cycle).
//  - Latency with zero-wait completer: accept in cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3.
//    Min 4 cycles per transfer; no pipelining, no command buffering.
//  - paddr/pwrite/pwdata stable from SETUP through the last ACCESS cycle; they hold their last value
//    in IDLE/RESP (no toggling).
//  - Watchdog: cleared on entry to SETUP; width $clog2(TIMEOUT_CYCLES+1), saturates, no wrap.
//    Timeout abort deasserts psel without pready (deliberate protocol exception for recovery).
//  - pready sampled only in ACCESS; pready/pslverr/prdata ignored in IDLE/SETUP/RESP.
//  - pslverr with pready: response completes normally with rsp_err=1, rsp_timeout=0.
//  - pready=1 in the same cycle as watchdog reaching its limit: completion wins, no timeout.
//  - rsp_ready asserted while rsp_valid=0: ignored. req_valid while busy: stalled by req_ready=0,
//    never dropped.
//  - Reset mid-transfer: immediate return to reset values (psel/penable low asynchronously);
//    the in-flight command and response are lost.
// STRUCTURE
//  - apb_pkg: typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS, APB_RESP} apb_mst_state_e;
//    shared default width constants APB_ADDR_W_DEF=32, APB_DATA_W_DEF=32.
//  - Single module plus one natural sub-module, apb_wdt_cnt (clear/enable/limit -> expired pulse).
//  - Connects to the team APB interface through its Master modport at the parent level.
// TESTING
//  1 Reset: assert prst mid-ACCESS -> psel=penable=0 and rsp_valid=0 same cycle; req_ready=1 after release.
//  2 Write addr=0x10, data=0xA5A5_0001, pready=1 always -> psel high N+1..N+2, penable N+2 only;
//    rsp_valid N+3, rsp_err=0, rsp_rdata=0.
//  3 Read addr=0x04, completer inserts 3 wait states, prdata=0xDEAD_BEEF -> paddr stable 5 cycles;
//    rsp_rdata=0xDEAD_BEEF at N+6.
//  4 Read with pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  5 TIMEOUT_CYCLES=16, pready stuck 0 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1;
//    next command then completes normally.
//  6 Backpressure: rsp_ready low 5 cycles, req_valid high -> response fields stable, req_ready=0,
//    second command issued only after the response handshake.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS,
        APB_RESP
    } apb_mst_state_e;

    localparam int APB_ADDR_W_DEF = 32;
    localparam int APB_DATA_W_DEF = 32;

    // Watchdog counter width; a disabled watchdog (limit 0) still needs one bit.
    function automatic int wdt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// APB3 bus bundle between a requester (master) and a completer (slave).
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W_DEF,
    parameter int DATA_W = APB_DATA_W_DEF
);

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_wdt_cnt.sv
// Saturating watchdog: counts enabled cycles since clear and pulses expired on the
// cycle whose count reaches LIMIT. LIMIT == 0 never expires.
module apb_wdt_cnt
    import apb_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = wdt_width(LIMIT);
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
    localparam logic [W-1:0] LAST_W  = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT_W)) begin
            cnt <= cnt + W'(1);
        end
    end

    // The cycle that would bump the count to LIMIT is the abort cycle.
    assign expired = (LIMIT != 0) && enable && (cnt == LAST_W);

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: one valid/ready command becomes one SETUP->ACCESS transfer, whose
// result is held on the response port until consumed. Watchdog aborts a hung completer.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = APB_ADDR_W_DEF,
    parameter int APB_DATA_WIDTH = APB_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      prst,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_write,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,

    apb_master_bridge_if.master       apb
);

    apb_mst_state_e state;
    logic           wdt_clear;
    logic           wdt_enable;
    logic           wdt_expired;

    assign wdt_clear  = (state == APB_IDLE) && req_valid;
    assign wdt_enable = (state == APB_ACCESS) && !apb.pready;

    apb_wdt_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .pclk    (pclk),
        .prst    (prst),
        .clear   (wdt_clear),
        .enable  (wdt_enable),
        .expired (wdt_expired)
    );

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state       <= APB_IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            apb.paddr   <= '0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite  <= 1'b0;
            apb.pwdata  <= '0;
        end else begin
            case (state)
                APB_IDLE: begin
                    if (req_valid) begin
                        apb.paddr  <= req_addr;
                        apb.pwrite <= req_write;
                        apb.pwdata <= req_wdata;
                        apb.psel   <= 1'b1;
                        req_ready  <= 1'b0;
                        state      <= APB_SETUP;
                    end
                end

                APB_SETUP: begin
                    apb.penable <= 1'b1;
                    state       <= APB_ACCESS;
                end

                APB_ACCESS: begin
                    // Completion is tested first so pready on the limit cycle wins.
                    if (apb.pready) begin
                        rsp_rdata   <= (apb.pwrite || apb.pslverr) ? '0 : apb.prdata;
                        rsp_err     <= apb.pslverr;
                        rsp_timeout <= 1'b0;
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= APB_RESP;
                    end else if (wdt_expired) begin
                        // Deliberate protocol exception: psel drops without pready to recover.
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        apb.psel    <= 1'b0;
                        apb.penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        state       <= APB_RESP;
                    end
                end

                APB_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        req_ready   <= 1'b1;
                        state       <= APB_IDLE;
                    end
                end

                default: state <= APB_IDLE;
            endcase
        end
    end

endmodule
